// File: rtl/kyber_pkg.sv
// kyber_pkg: Kyber constants, bit-reversed zeta table and transform state enum shared by ntt/intt
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam logic [11:0] INV_128 = 12'd3303;
  typedef enum logic [1:0] {IDLE, BFLY, SCALE, DONE} state_t;
  typedef logic [127:0][11:0] zeta_tbl_t;
  // zeta[k] = 17^BitRev7(k) mod Q; exponent bit i is bit 6-i of k, so square-and-multiply reads k from the top
  function automatic zeta_tbl_t gen_zetas();
    zeta_tbl_t t;
    for (int k = 0; k < 128; k++) begin
      int p;
      int b;
      p = 1;
      b = 17;
      for (int i = 0; i < 7; i++) begin
        if (k[6-i]) p = p * b % KYBER_Q;
        b = b * b % KYBER_Q;
      end
      t[k] = 12'(p);
    end
    return t;
  endfunction
  localparam zeta_tbl_t ZETAS = gen_zetas();
endpackage

// File: rtl/intt_butterfly.sv
// intt_butterfly: Gentleman-Sande butterfly, sum = a+b mod Q, prod = zeta*(b-a) mod Q
module intt_butterfly
  import kyber_pkg::*;
(
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [11:0] zeta,
  output logic [11:0] sum,
  output logic [11:0] prod
);
  logic [12:0] s;
  logic [12:0] dd;
  logic [11:0] d;
  logic [23:0] p;
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    sum = s >= 13'(KYBER_Q) ? 12'(s - 13'(KYBER_Q)) : s[11:0];
    dd = {1'b0, b} + 13'(KYBER_Q) - {1'b0, a};
    d = dd >= 13'(KYBER_Q) ? 12'(dd - 13'(KYBER_Q)) : dd[11:0];
    p = 24'(zeta) * 24'(d);
    prod = 12'(p % 24'(KYBER_Q));
  end
endmodule

// File: rtl/intt.sv
// intt: sequential Kyber inverse NTT, one butterfly per cycle followed by one 1/128 scaling per cycle
module intt
  import kyber_pkg::*;
#(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] f_hat [N],
  output logic signed [15:0] f [N],
  output logic               done
);
  state_t st;
  logic [11:0] a [N];
  logic [2:0] layer;
  logic [8:0] idx;
  logic [6:0] k;
  logic [7:0] len, j, jl;
  logic [6:0] mask;
  logic [11:0] ba, bb, bz, sum, prod;
  function automatic logic [11:0] modq(input logic signed [15:0] v);
    int r;
    r = int'(v) % Q;
    return 12'(r < 0 ? r + Q : r);
  endfunction
  // j inserts a zero at bit layer+1 of the butterfly counter, giving ascending j within each layer
  always_comb begin
    len = 8'(8'd2 << layer);
    mask = 7'(len - 8'd1);
    j = {idx[6:0] & ~mask, 1'b0} | {1'b0, idx[6:0] & mask};
    jl = j | len;
    ba = st == SCALE ? 12'd0 : a[j];
    bb = st == SCALE ? a[idx[7:0]] : a[jl];
    bz = st == SCALE ? INV_128 : ZETAS[k];
  end
  intt_butterfly u_bfly (.a(ba), .b(bb), .zeta(bz), .sum(sum), .prod(prod));
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      done <= 1'b0;
      layer <= '0;
      idx <= '0;
      k <= '0;
      for (int i = 0; i < N; i++) begin
        a[i] <= '0;
        f[i] <= '0;
      end
    end else begin
      case (st)
        IDLE, DONE: if (start) begin
          for (int i = 0; i < N; i++) a[i] <= modq(f_hat[i]);
          done <= 1'b0;
          layer <= '0;
          idx <= '0;
          k <= 7'd127;
          st <= BFLY;
        end
        BFLY: begin
          a[j] <= sum;
          a[jl] <= prod;
          if ((idx[6:0] & mask) == mask) k <= k - 7'd1;
          if (idx[6:0] == 7'd127) begin
            idx <= '0;
            layer <= layer + 3'd1;
            if (layer == 3'd6) st <= SCALE;
          end else idx <= idx + 9'd1;
        end
        SCALE: if (idx == 9'd256) begin
          for (int i = 0; i < N; i++) f[i] <= {4'b0, a[i]};
          done <= 1'b1;
          st <= DONE;
        end else begin
          a[idx[7:0]] <= prod;
          idx <= idx + 9'd1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intt.sv
// tb_intt: randomized and directed checks of intt against a textbook inverse/forward NTT model
module tb_intt;
  localparam int Q = 3329;
  localparam int LAT = 1153;
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic signed [15:0] f_hat [256];
  logic signed [15:0] f [256];
  logic done;
  int nchk = 0;
  int nerr = 0;
  int vin [256];
  int vexp [256];
  int prev [256];

  intt dut (.clk(clk), .reset(reset), .start(start), .f_hat(f_hat), .f(f), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int zeta(input int k);
    int br = 0;
    int p = 1;
    for (int i = 0; i < 7; i++) if (((k >> i) & 1) == 1) br |= 1 << (6 - i);
    for (int e = 0; e < br; e++) p = p * 17 % Q;
    return p;
  endfunction

  function automatic void inv_ntt();
    int x [256];
    int k = 127;
    for (int i = 0; i < 256; i++) x[i] = ((vin[i] % Q) + Q) % Q;
    for (int len = 2; len <= 128; len *= 2)
      for (int s = 0; s < 256; s += 2 * len) begin
        int z = zeta(k);
        k--;
        for (int jj = s; jj < s + len; jj++) begin
          int t = x[jj];
          x[jj] = (t + x[jj + len]) % Q;
          x[jj + len] = z * ((x[jj + len] - t + Q) % Q) % Q;
        end
      end
    for (int i = 0; i < 256; i++) vexp[i] = x[i] * 3303 % Q;
  endfunction

  function automatic void fwd_ntt();
    int x [256];
    int k = 1;
    for (int i = 0; i < 256; i++) x[i] = ((vexp[i] % Q) + Q) % Q;
    for (int len = 128; len >= 2; len /= 2)
      for (int s = 0; s < 256; s += 2 * len) begin
        int z = zeta(k);
        k++;
        for (int jj = s; jj < s + len; jj++) begin
          int t = z * x[jj + len] % Q;
          x[jj + len] = (x[jj] - t + Q) % Q;
          x[jj] = (x[jj] + t) % Q;
        end
      end
    for (int i = 0; i < 256; i++) vin[i] = x[i];
  endfunction

  task automatic apply();
    for (int i = 0; i < 256; i++) f_hat[i] = 16'(vin[i]);
  endtask

  task automatic check_f(input string tag);
    for (int i = 0; i < 256; i++) check($sformatf("%s[%0d]", tag, i), 32'(f[i]), 32'(vexp[i]));
    for (int i = 0; i < 256; i++) prev[i] = vexp[i];
  endtask

  task automatic set_const(input int even, input int odd);
    for (int i = 0; i < 128; i++) begin
      vin[2 * i] = even;
      vin[2 * i + 1] = odd;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 256; i++) vin[i] = int'($signed(16'($urandom)));
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 256; i++) vexp[i] = 0;
  endtask

  // pulse start (held for hold cycles, optional extra pulse at cycle pulse_at), optional reset at cycle rst_at
  task automatic run(input int hold, input int pulse_at, input int rst_at);
    int c = 0;
    int pi = int'($urandom_range(0, 255));
    apply();
    start = 1'b1;
    @(negedge clk);
    check("done_clr", 32'(done), 32'd0);
    start = (c + 1 < hold) || (c == pulse_at);
    while (!done && c < LAT + 100) begin
      @(negedge clk);
      c++;
      start = (c + 1 < hold) || (c == pulse_at);
      if (c == 600) check("f_hold", 32'(f[pi]), 32'(prev[pi]));
      if (c == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_done", 32'(done), 32'd0);
        clr_exp();
        check_f("rst_f");
        return;
      end
    end
    start = 1'b0;
    check("latency", 32'(c), 32'(LAT));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) vin[i] = 0;
    apply();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_done", 32'(done), 32'd0);
    clr_exp();
    check_f("reset_f");
    run(1, -1, -1);
    clr_exp();
    check_f("zero");
    set_const(5, 0);
    run(1, -1, -1);
    clr_exp();
    vexp[0] = 5;
    check_f("const5");
    set_const(-1, 0);
    run(1, -1, -1);
    clr_exp();
    vexp[0] = 3328;
    check_f("constm1");
    set_const(0, 1);
    run(1, -1, -1);
    clr_exp();
    vexp[1] = 1;
    check_f("odd1");
    clr_exp();
    vexp[1] = 1;
    vexp[3] = -1;
    vexp[254] = 1;
    vexp[255] = -1;
    fwd_ntt();
    run(1, -1, -1);
    clr_exp();
    vexp[1] = 1;
    vexp[3] = 3328;
    vexp[254] = 1;
    vexp[255] = 3328;
    check_f("roundtrip");
    for (int r = 0; r < 2; r++) begin
      set_rand();
      inv_ntt();
      run(1, -1, -1);
      check_f($sformatf("rand%0d", r));
    end
    set_rand();
    inv_ntt();
    run(2, 300, -1);
    check_f("held");
    repeat (5) @(negedge clk);
    check("done_level", 32'(done), 32'd1);
    set_rand();
    run(1, -1, 1000);
    repeat (LAT + 20) @(negedge clk);
    check("idle_after_rst", 32'(done), 32'd0);
    set_rand();
    inv_ntt();
    run(1, -1, -1);
    check_f("b2b_a");
    set_rand();
    inv_ntt();
    run(1, -1, -1);
    check_f("b2b_b");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/intt.md
INTT -- requirements
Module: intt

Interface
REQ-001 SHALL have parameter N, default 256, number of coefficients per polynomial.
REQ-002 SHALL have parameter Q, default 3329, Kyber modulus.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to transform the current f_hat.
REQ-006 SHALL have port f_hat, input, signed 16 x N unpacked, NTT-domain coefficients.
REQ-007 SHALL have port f, output, signed 16 x N unpacked, registered, normal-domain result.
REQ-008 SHALL have port done, output, 1, result valid.

Function
REQ-009 SHALL compute the Kyber inverse NTT (Gentleman-Sande): k=127; len = 2,4,...,128; per block zeta = 17^BitRev7(k) mod Q, k decrements; per butterfly t=a[j], a[j]=(t+a[j+len]) mod Q, a[j+len]=zeta*(a[j+len]-t) mod Q; then every coefficient is multiplied by 3303 mod Q.
REQ-010 SHALL implement states IDLE, BFLY, SCALE, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; on the accepting edge, all N inputs are captured in parallel, each reduced to [0,Q-1] (negative values map to value+kQ), done clears, and the state becomes BFLY.
REQ-012 SHALL ignore start while in BFLY or SCALE; start held high for several cycles SHALL cause exactly one transform.
REQ-013 SHALL perform exactly one butterfly per cycle in BFLY: 7 layers x 128 = 896 cycles, in ascending j order within each layer.
REQ-014 SHALL scale one coefficient per cycle in SCALE, indices 0..255: 256 cycles.
REQ-015 SHALL assert done and transition to DONE on the edge 1153 cycles after the accepting edge; done is level and holds until the next accepted start or reset.
REQ-016 SHALL update f only when entering DONE, with all N scaled values in [0,Q-1]; f SHALL hold the previous result while busy.
REQ-017 SHALL keep all internal coefficients 12-bit unsigned in [0,Q-1]; subtraction adds Q before reduction; products use a 24-bit intermediate with exact mod-Q reduction (Barrett or equivalent), never truncated.
REQ-018 SHALL restart a new transform from the freshly captured input when start is accepted in DONE (back-to-back).

Reset
REQ-019 SHALL on reset, regardless of state, return to IDLE, clear done to 0, clear all f entries and internal coefficients to 0, and zero the layer, index and k counters.
REQ-020 SHALL give reset priority over start in the same cycle.

Structure
REQ-021 SHALL take KYBER_Q, KYBER_N, INV_128 (3303), the 128-entry bit-reversed zeta table, and a state enum from shared package kyber_pkg, shared with ntt.
REQ-022 SHALL instantiate one combinational sub-module intt_butterfly (inputs a, b, zeta; outputs a+b mod Q and zeta*(b-a) mod Q), also used for scaling with zeta=INV_128 and a=0.
REQ-023 SHALL use no multi-cycle or false paths; the butterfly is single-cycle.

Verification
REQ-024 SHALL cover all-zero f_hat: pulse start -> done rises exactly 1153 cycles after accept, all f = 0.
REQ-025 SHALL cover constant input f_hat[2i]=5, f_hat[2i+1]=0 -> f[0]=5, all other f = 0; repeat with f_hat[2i]=-1 -> f[0]=3328, rest 0.
REQ-026 SHALL cover f_hat[2i+1]=1, f_hat[2i]=0 -> f[1]=1, all other f = 0.
REQ-027 SHALL cover round trip: ntt output of the vector f[1]=1, f[3]=-1, f[255]=-1, f[254]=1 (others 0) fed to intt -> f[1]=1, f[3]=3328, f[254]=1, f[255]=3328, rest 0.
REQ-028 SHALL cover start held 2 cycles, plus start re-pulsed mid-BFLY -> exactly one done rise at 1153 cycles; then reset asserted mid-SCALE -> next cycle done=0, f all 0, IDLE.
REQ-029 SHALL cover back-to-back: start in DONE with new f_hat -> done drops next cycle and rises 1153 cycles later with the new result.
